// File: rtl/instruction_memory_loadable_if.sv
// Byte-stream program load and instruction fetch bus for instruction_memory_loadable.
interface instruction_memory_loadable_if #(
  parameter int unsigned DEPTH = 1024
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          load_start;
  logic          load_valid;
  logic [7:0]    load_byte;
  logic          load_last;
  logic          load_busy;
  logic          load_overflow;
  logic [CW-1:0] loaded_words;
  logic          fetch_req;
  logic [31:0]   fetch_addr;
  logic          fetch_ready;
  logic          instr_valid;
  logic [31:0]   instr_out;
  logic          fault_misaligned;
  logic          fault_range;

  modport master (
    output load_start, load_valid, load_byte, load_last, fetch_req, fetch_addr,
    input  load_busy, load_overflow, loaded_words, fetch_ready,
           instr_valid, instr_out, fault_misaligned, fault_range
  );

  modport slave (
    input  load_start, load_valid, load_byte, load_last, fetch_req, fetch_addr,
    output load_busy, load_overflow, loaded_words, fetch_ready,
           instr_valid, instr_out, fault_misaligned, fault_range
  );
endinterface

// File: rtl/instruction_memory_loadable.sv
// Instruction memory filled by a little-endian byte stream, read by single-cycle fetches
// with misalignment and out-of-range fault reporting.
module instruction_memory_loadable #(
  parameter int unsigned DEPTH       = 1024,
  parameter logic [31:0] FAULT_INSTR = 32'hDEADBEEF,
  parameter logic [31:0] NOP_INSTR   = 32'h00000013
) (
  input logic                       clk,
  input logic                       reset,
  instruction_memory_loadable_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {EMPTY, LOAD, READY} state_t;

  state_t         state, state_nxt;
  logic [1:0]     lane;
  logic [31:0]    partial;
  logic [31:0]    word_asm;
  logic [CW-1:0]  words_q;
  logic           overflow_q;
  logic           byte_acc;
  logic           mem_full;
  logic           word_done;
  logic           fetch_acc;
  logic [29:0]    fetch_idx;
  logic           mis_c;
  logic           rng_c;
  logic           valid_q;
  logic [31:0]    instr_q;
  logic           mis_q;
  logic           rng_q;
  logic [31:0]    mem [DEPTH];

  // load_start always wins over a byte offered in the same cycle
  assign byte_acc  = (state == LOAD) && bus.load_valid && !bus.load_start;
  assign mem_full  = (words_q == CW'(DEPTH));
  assign word_done = byte_acc && !mem_full && ((lane == 2'd3) || bus.load_last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.load_start)                 state_nxt = LOAD;
    else if (byte_acc && bus.load_last) state_nxt = READY;
  end

  always_comb begin
    bus.load_busy   = 1'b0;
    bus.fetch_ready = 1'b0;
    case (state)
      LOAD:    bus.load_busy   = 1'b1;
      READY:   bus.fetch_ready = 1'b1;
      default: ;
    endcase
  end

  // Lanes above the current one are still zero, so a short final word is zero-padded
  always_comb begin
    word_asm = partial;
    word_asm[{lane, 3'b000} +: 8] = bus.load_byte;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane       <= 2'd0;
      partial    <= 32'd0;
      words_q    <= '0;
      overflow_q <= 1'b0;
    end else if (bus.load_start) begin
      lane       <= 2'd0;
      partial    <= 32'd0;
      words_q    <= '0;
      overflow_q <= 1'b0;
    end else if (byte_acc) begin
      if (mem_full) begin
        overflow_q <= 1'b1;
      end else if (word_done) begin
        lane    <= 2'd0;
        partial <= 32'd0;
        words_q <= words_q + CW'(1);
      end else begin
        lane    <= lane + 2'd1;
        partial <= word_asm;
      end
    end
  end

  // Array is deliberately not reset; contents survive reloads
  always_ff @(posedge clk) begin
    if (word_done) mem[words_q[AW-1:0]] <= word_asm;
  end

  assign fetch_acc = bus.fetch_req && (state == READY);
  assign fetch_idx = bus.fetch_addr[31:2];
  assign mis_c     = |bus.fetch_addr[1:0];
  assign rng_c     = fetch_idx >= 30'(words_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      mis_q   <= 1'b0;
      rng_q   <= 1'b0;
    end else begin
      valid_q <= fetch_acc;
      mis_q   <= fetch_acc && mis_c;
      rng_q   <= fetch_acc && rng_c;
      if (fetch_acc) instr_q <= (mis_c || rng_c) ? FAULT_INSTR : mem[fetch_idx[AW-1:0]];
    end
  end

  assign bus.load_overflow    = overflow_q;
  assign bus.loaded_words     = words_q;
  assign bus.instr_valid      = valid_q;
  assign bus.instr_out        = instr_q;
  assign bus.fault_misaligned = mis_q;
  assign bus.fault_range      = rng_q;
endmodule

// File: tb/tb_instruction_memory_loadable.sv
// Directed bench for instruction_memory_loadable: loads, fetches, faults, overflow, reset abort.
module tb_instruction_memory_loadable;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   pass_cnt = 0;
  int   total = 0;

  instruction_memory_loadable_if #(.DEPTH(1024)) m ();
  instruction_memory_loadable_if #(.DEPTH(4))    m4 ();

  instruction_memory_loadable #(.DEPTH(1024)) dut  (.clk(clk), .reset(reset), .bus(m));
  instruction_memory_loadable #(.DEPTH(4))    dut4 (.clk(clk), .reset(reset), .bus(m4));

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic start_load;
    m.load_start = 1'b1;
    step();
    m.load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    m.load_valid = 1'b1;
    m.load_byte  = b;
    m.load_last  = last;
    step();
    m.load_valid = 1'b0;
    m.load_last  = 1'b0;
  endtask

  task automatic do_fetch(input logic [31:0] a);
    m.fetch_req  = 1'b1;
    m.fetch_addr = a;
    step();
    m.fetch_req  = 1'b0;
  endtask

  task automatic test_reset;
    total++; if (m.load_busy !== 1'b0) $display("FAIL rst_busy got %b want 0", m.load_busy); else pass_cnt++;
    total++; if (m.load_overflow !== 1'b0) $display("FAIL rst_ovf got %b want 0", m.load_overflow); else pass_cnt++;
    total++; if (m.loaded_words !== 11'd0) $display("FAIL rst_words got %0d want 0", m.loaded_words); else pass_cnt++;
    total++; if (m.fetch_ready !== 1'b0) $display("FAIL rst_ready got %b want 0", m.fetch_ready); else pass_cnt++;
    total++; if (m.instr_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", m.instr_valid); else pass_cnt++;
    total++; if (m.instr_out !== 32'h00000013) $display("FAIL rst_instr got %h want 00000013", m.instr_out); else pass_cnt++;
  endtask

  task automatic test_basic_load;
    start_load();
    total++; if (m.load_busy !== 1'b1) $display("FAIL load_busy got %b want 1", m.load_busy); else pass_cnt++;
    send_byte(8'h13, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h93, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h10, 1'b0); send_byte(8'h00, 1'b1);
    total++; if (m.loaded_words !== 11'd2) $display("FAIL basic_words got %0d want 2", m.loaded_words); else pass_cnt++;
    total++; if (m.fetch_ready !== 1'b1) $display("FAIL basic_ready got %b want 1", m.fetch_ready); else pass_cnt++;
    total++; if (m.load_busy !== 1'b0) $display("FAIL basic_busy got %b want 0", m.load_busy); else pass_cnt++;
    do_fetch(32'h0);
    total++; if (m.instr_valid !== 1'b1) $display("FAIL basic_v0 got %b want 1", m.instr_valid); else pass_cnt++;
    total++; if (m.instr_out !== 32'h00000013) $display("FAIL basic_i0 got %h want 00000013", m.instr_out); else pass_cnt++;
    do_fetch(32'h4);
    total++; if (m.instr_out !== 32'h00100093) $display("FAIL basic_i1 got %h want 00100093", m.instr_out); else pass_cnt++;
    total++; if (m.fault_range !== 1'b0) $display("FAIL basic_rng got %b want 0", m.fault_range); else pass_cnt++;
  endtask

  task automatic test_partial_range;
    start_load();
    send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b0); send_byte(8'hCC, 1'b0);
    send_byte(8'hDD, 1'b0); send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b1);
    total++; if (m.loaded_words !== 11'd2) $display("FAIL part_words got %0d want 2", m.loaded_words); else pass_cnt++;
    do_fetch(32'h4);
    total++; if (m.instr_out !== 32'h00002211) $display("FAIL part_i1 got %h want 00002211", m.instr_out); else pass_cnt++;
    do_fetch(32'h8);
    total++; if (m.fault_range !== 1'b1) $display("FAIL part_rng got %b want 1", m.fault_range); else pass_cnt++;
    total++; if (m.fault_misaligned !== 1'b0) $display("FAIL part_mis got %b want 0", m.fault_misaligned); else pass_cnt++;
    total++; if (m.instr_out !== 32'hDEADBEEF) $display("FAIL part_fault got %h want deadbeef", m.instr_out); else pass_cnt++;
    step();
    total++; if (m.instr_valid !== 1'b0) $display("FAIL hold_valid got %b want 0", m.instr_valid); else pass_cnt++;
    total++; if (m.fault_range !== 1'b0) $display("FAIL hold_rng got %b want 0", m.fault_range); else pass_cnt++;
    total++; if (m.instr_out !== 32'hDEADBEEF) $display("FAIL hold_instr got %h want deadbeef", m.instr_out); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    do_fetch(32'h2);
    total++; if (m.fault_misaligned !== 1'b1) $display("FAIL mis_flag got %b want 1", m.fault_misaligned); else pass_cnt++;
    total++; if (m.fault_range !== 1'b0) $display("FAIL mis_rng got %b want 0", m.fault_range); else pass_cnt++;
    total++; if (m.instr_out !== 32'hDEADBEEF) $display("FAIL mis_instr got %h want deadbeef", m.instr_out); else pass_cnt++;
    m.fetch_req = 1'b1; m.fetch_addr = 32'h0;
    step();
    total++; if (m.instr_valid !== 1'b1) $display("FAIL b2b_v0 got %b want 1", m.instr_valid); else pass_cnt++;
    total++; if (m.instr_out !== 32'hDDCCBBAA) $display("FAIL b2b_i0 got %h want ddccbbaa", m.instr_out); else pass_cnt++;
    m.fetch_addr = 32'h4;
    step();
    m.fetch_req = 1'b0;
    total++; if (m.instr_valid !== 1'b1) $display("FAIL b2b_v1 got %b want 1", m.instr_valid); else pass_cnt++;
    total++; if (m.instr_out !== 32'h00002211) $display("FAIL b2b_i1 got %h want 00002211", m.instr_out); else pass_cnt++;
  endtask

  task automatic test_fetch_with_load_start;
    m.fetch_req = 1'b1; m.fetch_addr = 32'h0; m.load_start = 1'b1;
    step();
    m.fetch_req = 1'b0; m.load_start = 1'b0;
    total++; if (m.instr_valid !== 1'b1) $display("FAIL fls_valid got %b want 1", m.instr_valid); else pass_cnt++;
    total++; if (m.instr_out !== 32'hDDCCBBAA) $display("FAIL fls_instr got %h want ddccbbaa", m.instr_out); else pass_cnt++;
    total++; if (m.loaded_words !== 11'd0) $display("FAIL fls_words got %0d want 0", m.loaded_words); else pass_cnt++;
    total++; if (m.fetch_ready !== 1'b0) $display("FAIL fls_ready got %b want 0", m.fetch_ready); else pass_cnt++;
  endtask

  task automatic test_overflow;
    m4.load_start = 1'b1;
    step();
    m4.load_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      m4.load_valid = 1'b1;
      m4.load_byte  = 8'(i);
      m4.load_last  = (i == 19);
      step();
    end
    m4.load_valid = 1'b0; m4.load_last = 1'b0;
    total++; if (m4.loaded_words !== 3'd4) $display("FAIL ovf_words got %0d want 4", m4.loaded_words); else pass_cnt++;
    total++; if (m4.load_overflow !== 1'b1) $display("FAIL ovf_flag got %b want 1", m4.load_overflow); else pass_cnt++;
    total++; if (m4.fetch_ready !== 1'b1) $display("FAIL ovf_ready got %b want 1", m4.fetch_ready); else pass_cnt++;
    m4.fetch_req = 1'b1; m4.fetch_addr = 32'h0;
    step();
    total++; if (m4.instr_out !== 32'h03020100) $display("FAIL ovf_i0 got %h want 03020100", m4.instr_out); else pass_cnt++;
    m4.fetch_addr = 32'hC;
    step();
    total++; if (m4.instr_out !== 32'h0F0E0D0C) $display("FAIL ovf_i3 got %h want 0f0e0d0c", m4.instr_out); else pass_cnt++;
    m4.fetch_addr = 32'h10;
    step();
    m4.fetch_req = 1'b0;
    total++; if (m4.fault_range !== 1'b1) $display("FAIL ovf_rng got %b want 1", m4.fault_range); else pass_cnt++;
  endtask

  task automatic test_reset_midload;
    start_load();
    send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h03, 1'b0);
    send_byte(8'h04, 1'b0); send_byte(8'h05, 1'b0);
    #2 reset = 1'b1;
    #1;
    total++; if (m.loaded_words !== 11'd0) $display("FAIL mrst_words got %0d want 0", m.loaded_words); else pass_cnt++;
    total++; if (m.load_busy !== 1'b0) $display("FAIL mrst_busy got %b want 0", m.load_busy); else pass_cnt++;
    total++; if (m.fetch_ready !== 1'b0) $display("FAIL mrst_ready got %b want 0", m.fetch_ready); else pass_cnt++;
    total++; if (m.instr_out !== 32'h00000013) $display("FAIL mrst_instr got %h want 00000013", m.instr_out); else pass_cnt++;
    step();
    reset = 1'b0;
    m.fetch_req = 1'b1; m.fetch_addr = 32'h0;
    step();
    total++; if (m.instr_valid !== 1'b0) $display("FAIL empty_v0 got %b want 0", m.instr_valid); else pass_cnt++;
    step();
    m.fetch_req = 1'b0;
    total++; if (m.instr_valid !== 1'b0) $display("FAIL empty_v1 got %b want 0", m.instr_valid); else pass_cnt++;
  endtask

  initial begin
    m.load_start = 1'b0;  m.load_valid = 1'b0;  m.load_byte = 8'h00;  m.load_last = 1'b0;
    m.fetch_req  = 1'b0;  m.fetch_addr = 32'h0;
    m4.load_start = 1'b0; m4.load_valid = 1'b0; m4.load_byte = 8'h00; m4.load_last = 1'b0;
    m4.fetch_req  = 1'b0; m4.fetch_addr = 32'h0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    test_reset();
    test_basic_load();
    test_partial_range();
    test_back_to_back();
    test_fetch_with_load_start();
    test_overflow();
    test_reset_midload();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/instruction_memory_loadable.md
INSTRUCTION_MEMORY_LOADABLE -- requirements
Module: instruction_memory_loadable

Interface
REQ-001 Parameter DEPTH, default 1024, instruction words stored (power of two, >= 4).
REQ-002 Parameter FAULT_INSTR, default 32'hDEADBEEF, word returned on any fetch fault.
REQ-003 Parameter NOP_INSTR, default 32'h00000013, instr_out value after reset.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 load_start  input  1  one-cycle pulse beginning a program load.
REQ-007 load_valid  input  1  load_byte carries a program byte this cycle.
REQ-008 load_byte  input  8  program byte, little-endian within each word.
REQ-009 load_last  input  1  qualifies load_byte as the final program byte.
REQ-010 load_busy  output  1  high while in LOAD state.
REQ-011 load_overflow  output  1  sticky: bytes were offered beyond DEPTH words.
REQ-012 loaded_words  output  $clog2(DEPTH)+1  count of words written by the last load.
REQ-013 fetch_req  input  1  fetch request.
REQ-014 fetch_addr  input  32  byte address of requested instruction.
REQ-015 fetch_ready  output  1  fetch accepted when fetch_req && fetch_ready.
REQ-016 instr_valid  output  1  instr_out and fault flags valid this cycle.
REQ-017 instr_out  output  32  fetched instruction.
REQ-018 fault_misaligned  output  1  accepted fetch had fetch_addr[1:0] != 0.
REQ-019 fault_range  output  1  accepted fetch word index >= loaded_words.

Function
REQ-020 FSM states EMPTY, LOAD, READY; EMPTY->LOAD and READY->LOAD on load_start; LOAD->READY on accepted byte with load_last.
REQ-021 load_start in LOAD restarts: word pointer 0, partial word discarded, loaded_words 0, load_overflow cleared.
REQ-022 Entering LOAD clears word pointer, byte lane, loaded_words, load_overflow.
REQ-023 In LOAD, byte accepted when load_valid; byte lane k (0..3) fills bits [8k+7:8k]; lane increments modulo 4.
REQ-024 On lane-3 byte the assembled word is written to mem[pointer], pointer and loaded_words increment by 1.
REQ-025 load_last on lanes 0..2: unfilled upper bytes zero, word written, loaded_words increments.
REQ-026 When loaded_words == DEPTH, further bytes are not written and set load_overflow; load_last still moves to READY.
REQ-027 load_valid outside LOAD ignored; load_last without load_valid ignored.
REQ-028 fetch_ready = 1 only in READY (combinational from state).
REQ-029 Accepted fetch yields instr_valid = 1 exactly one cycle later, for one cycle; one fetch per cycle sustained.
REQ-030 Word index = fetch_addr[31:2]; instr_out = mem[index] when aligned and index < loaded_words.
REQ-031 Misaligned: fault_misaligned = 1, instr_out = FAULT_INSTR; fault_range also evaluated.
REQ-032 index >= loaded_words (full 30-bit compare, no wrap): fault_range = 1, instr_out = FAULT_INSTR.
REQ-033 When instr_valid = 0, instr_out holds last value; fault flags are 0.
REQ-034 Fetch accepted in the same cycle as load_start completes normally using pre-load contents and loaded_words.
REQ-035 Memory array is never reset; contents persist across loads except overwritten words.

Reset
REQ-036 reset drives: state EMPTY, pointer/lane 0, loaded_words 0, load_busy 0, load_overflow 0, fetch_ready 0, instr_valid 0, instr_out NOP_INSTR, faults 0.
REQ-037 reset mid-load or mid-fetch aborts immediately; no instr_valid issued for in-flight fetch.

Verification
REQ-038 Load 8 bytes 13,00,00,00,93,00,10,00 (last on 8th) -> loaded_words 2, READY; fetch 0x0 -> next cycle instr_valid, instr_out 32'h00000013; fetch 0x4 -> 32'h00100093.
REQ-039 Load 6 bytes AA,BB,CC,DD,11,22 -> loaded_words 2; fetch 0x4 -> 32'h00002211; fetch 0x8 -> fault_range 1, instr_out 32'hDEADBEEF.
REQ-040 Fetch 0x2 in READY -> fault_misaligned 1, instr_out 32'hDEADBEEF; fetches 0x0,0x4 back-to-back -> instr_valid on two consecutive cycles.
REQ-041 DEPTH=4, load 20 bytes -> loaded_words 4, load_overflow 1, mem[0..3] from first 16 bytes.
REQ-042 Assert reset after 5 load bytes -> EMPTY, loaded_words 0, fetch_ready 0, instr_out 32'h00000013; fetch_req in EMPTY -> no instr_valid.
